// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode: a DEPTH-entry FIFO of
// {instruction, PC+2} pairs that presents NOP to decode whenever it is empty.
module fetch_queue #(
    parameter int INSTR_W = 16,
    parameter int PC_W = 16,
    parameter int DEPTH = 4,
    parameter logic [INSTR_W-1:0] NOP = INSTR_W'(16'h0800)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    input  logic [INSTR_W-1:0]       enq_instr,
    input  logic [PC_W-1:0]          enq_pc_inc,
    output logic                     enq_ready,
    input  logic                     deq_ready,
    output logic                     deq_valid,
    output logic [INSTR_W-1:0]       deq_instr,
    output logic [PC_W-1:0]          deq_pc_inc,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             ovf_err_reg, ovf_err_next;

    logic do_enq;
    logic do_deq;
    logic full;
    logic empty;

    // Occupancy is tracked by the counter so pointers may wrap freely.
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    assign do_enq = enq_valid && !full && !flush;
    assign do_deq = deq_ready && !empty && !flush;

    always_comb begin
        rd_ptr_next  = rd_ptr_reg;
        wr_ptr_next  = wr_ptr_reg;
        count_next   = count_reg;
        ovf_err_next = ovf_err_reg;

        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_enq) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (do_deq) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
            if (enq_valid && full) begin
                ovf_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
            ovf_err_reg <= 1'b0;
        end else begin
            rd_ptr_reg  <= rd_ptr_next;
            wr_ptr_reg  <= wr_ptr_next;
            count_reg   <= count_next;
            ovf_err_reg <= ovf_err_next;
        end
    end

    // Payload storage is deliberately left unreset; stale slots are never shown.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            instr_mem[wr_ptr_reg] <= enq_instr;
            pc_mem[wr_ptr_reg]    <= enq_pc_inc;
        end
    end

    assign deq_valid  = !empty;
    assign deq_instr  = empty ? NOP : instr_mem[rd_ptr_reg];
    assign deq_pc_inc = empty ? '0 : pc_mem[rd_ptr_reg];
    assign enq_ready  = !full;
    assign count      = count_reg;
    assign ovf_err    = ovf_err_reg;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue: a table of single-cycle transactions
// plus hand sequences for flush and mid-cycle asynchronous reset.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        enq_valid;
    logic [15:0] enq_instr;
    logic [15:0] enq_pc_inc;
    logic        enq_ready;
    logic        deq_ready;
    logic        deq_valid;
    logic [15:0] deq_instr;
    logic [15:0] deq_pc_inc;
    logic        flush;
    logic [2:0]  count;
    logic        ovf_err;

    int total_checks = 0;
    int passed_checks = 0;

    fetch_queue #(
        .INSTR_W (16),
        .PC_W    (16),
        .DEPTH   (4),
        .NOP     (16'h0800)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enq_valid  (enq_valid),
        .enq_instr  (enq_instr),
        .enq_pc_inc (enq_pc_inc),
        .enq_ready  (enq_ready),
        .deq_ready  (deq_ready),
        .deq_valid  (deq_valid),
        .deq_instr  (deq_instr),
        .deq_pc_inc (deq_pc_inc),
        .flush      (flush),
        .count      (count),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [15:0] ei;
        logic [15:0] ep;
        logic        dr;
        logic        fl;
        logic [2:0]  ec;
        logic        evld;
        logic [15:0] eins;
        logic [15:0] epc;
        logic        erdy;
        logic        eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ev, input logic [15:0] ei, input logic [15:0] ep,
                       input logic dr, input logic fl, input logic [2:0] ec,
                       input logic evld, input logic [15:0] eins, input logic [15:0] epc,
                       input logic erdy, input logic eovf);
        vec_t v;
        v.ev = ev; v.ei = ei; v.ep = ep; v.dr = dr; v.fl = fl;
        v.ec = ec; v.evld = evld; v.eins = eins; v.epc = epc;
        v.erdy = erdy; v.eovf = eovf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] ec, input logic evld,
                               input logic [15:0] eins, input logic [15:0] epc,
                               input logic erdy, input logic eovf);
        chk({tag, " count"}, 32'(count), 32'(ec));
        chk({tag, " deq_valid"}, 32'(deq_valid), 32'(evld));
        chk({tag, " deq_instr"}, 32'(deq_instr), 32'(eins));
        chk({tag, " deq_pc_inc"}, 32'(deq_pc_inc), 32'(epc));
        chk({tag, " enq_ready"}, 32'(enq_ready), 32'(erdy));
        chk({tag, " ovf_err"}, 32'(ovf_err), 32'(eovf));
        $display("%s: count=%0d valid=%0b instr=%h pc=%h ready=%0b ovf=%0b",
                 tag, count, deq_valid, deq_instr, deq_pc_inc, enq_ready, ovf_err);
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic ev, input logic [15:0] ei, input logic [15:0] ep,
                        input logic dr, input logic fl);
        enq_valid  = ev;
        enq_instr  = ei;
        enq_pc_inc = ep;
        deq_ready  = dr;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        enq_valid = 0; enq_instr = 0; enq_pc_inc = 0; deq_ready = 0; flush = 0;

        // Ordering and latency through an empty queue.
        add(1, 16'hA001, 16'h0002, 1, 0, 3'd1, 1, 16'hA001, 16'h0002, 1, 0);
        add(1, 16'hA002, 16'h0004, 1, 0, 3'd1, 1, 16'hA002, 16'h0004, 1, 0);
        add(0, 16'h0000, 16'h0000, 1, 0, 3'd0, 0, 16'h0800, 16'h0000, 1, 0);
        // Wrap-around at steady occupancy 2 (pointers start at 2 here).
        add(1, 16'hC000, 16'h0100, 0, 0, 3'd1, 1, 16'hC000, 16'h0100, 1, 0);
        add(1, 16'hC001, 16'h0102, 0, 0, 3'd2, 1, 16'hC000, 16'h0100, 1, 0);
        for (int k = 2; k < 12; k++) begin
            add(1, 16'hC000 + 16'(k), 16'h0100 + 16'(2 * k), 1, 0, 3'd2, 1,
                16'hC000 + 16'(k - 1), 16'h0100 + 16'(2 * (k - 1)), 1, 0);
        end
        add(0, 16'h0000, 16'h0000, 1, 0, 3'd1, 1, 16'hC00B, 16'h0116, 1, 0);
        add(0, 16'h0000, 16'h0000, 1, 0, 3'd0, 0, 16'h0800, 16'h0000, 1, 0);
        // Decode stall, fill, overflow, then drain.
        add(1, 16'h1000, 16'h0010, 0, 0, 3'd1, 1, 16'h1000, 16'h0010, 1, 0);
        add(1, 16'h1001, 16'h0012, 0, 0, 3'd2, 1, 16'h1000, 16'h0010, 1, 0);
        add(1, 16'h1002, 16'h0014, 0, 0, 3'd3, 1, 16'h1000, 16'h0010, 1, 0);
        add(1, 16'h1003, 16'h0016, 0, 0, 3'd4, 1, 16'h1000, 16'h0010, 0, 0);
        add(1, 16'h1004, 16'h0018, 0, 0, 3'd4, 1, 16'h1000, 16'h0010, 0, 1);
        add(1, 16'h1005, 16'h001A, 1, 0, 3'd3, 1, 16'h1001, 16'h0012, 1, 1);
        add(0, 16'h0000, 16'h0000, 1, 0, 3'd2, 1, 16'h1002, 16'h0014, 1, 1);
        add(0, 16'h0000, 16'h0000, 1, 0, 3'd1, 1, 16'h1003, 16'h0016, 1, 1);
        add(0, 16'h0000, 16'h0000, 1, 0, 3'd0, 0, 16'h0800, 16'h0000, 1, 1);

        // Reset state, observed both during and after reset.
        @(posedge clk); #1;
        check_state("reset_held", 3'd0, 0, 16'h0800, 16'h0000, 1, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_state("reset_idle", 3'd0, 0, 16'h0800, 16'h0000, 1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].ev, vecs[i].ei, vecs[i].ep, vecs[i].dr, vecs[i].fl);
            check_state($sformatf("vec%0d", i), vecs[i].ec, vecs[i].evld,
                        vecs[i].eins, vecs[i].epc, vecs[i].erdy, vecs[i].eovf);
        end

        // Flush with simultaneous enqueue and dequeue; ovf_err must survive.
        step(1, 16'hD000, 16'h0200, 0, 0);
        step(1, 16'hD001, 16'h0202, 0, 0);
        step(1, 16'hD002, 16'h0204, 0, 0);
        check_state("pre_flush", 3'd3, 1, 16'hD000, 16'h0200, 1, 1);
        step(1, 16'hBEEF, 16'h0206, 1, 1);
        check_state("flush", 3'd0, 0, 16'h0800, 16'h0000, 1, 1);
        step(1, 16'hE000, 16'h0300, 0, 0);
        check_state("post_flush_enq", 3'd1, 1, 16'hE000, 16'h0300, 1, 1);
        step(0, 16'h0000, 16'h0000, 1, 0);
        check_state("post_flush_drain", 3'd0, 0, 16'h0800, 16'h0000, 1, 1);

        // Asynchronous reset between clock edges.
        step(1, 16'hF000, 16'h0400, 0, 0);
        step(1, 16'hF001, 16'h0402, 0, 0);
        step(1, 16'hF002, 16'h0404, 0, 0);
        step(0, 16'h0000, 16'h0000, 0, 0);
        check_state("pre_async_rst", 3'd3, 1, 16'hF000, 16'h0400, 1, 1);
        #2 rst = 1'b1;
        #1;
        check_state("async_rst", 3'd0, 0, 16'h0800, 16'h0000, 1, 0);
        #2 rst = 1'b0;
        step(1, 16'h1234, 16'h0500, 0, 0);
        check_state("after_rst_enq", 3'd1, 1, 16'h1234, 16'h0500, 1, 0);
        step(0, 16'h0000, 16'h0000, 1, 0);
        check_state("after_rst_drain", 3'd0, 0, 16'h0800, 16'h0000, 1, 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
